// File: rtl/alu_exec_seq_if.sv
// Request/response bundle between the multi-cycle controller and the
// sequential ALU execution unit.
//
// Handshake rules, both sides: a transfer happens on a rising clock edge
// where valid and ready are both 1. The sender holds valid and its payload
// steady until that edge. The receiver may raise or drop ready freely.
// On the request side the payload is code/a/b. On the response side it is
// result/flag_n/flag_z/flag_c/flag_v/err.
interface alu_exec_seq_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       code;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             err;

    // Controller side: issues requests and consumes results.
    modport master (
        output in_valid, code, a, b, out_ready,
        input  in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v, err
    );

    // Execution unit side.
    modport slave (
        input  in_valid, code, a, b, out_ready,
        output in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v, err
    );
endinterface

// File: rtl/alu_exec_seq.sv
// LEGv8 ALU execution unit. It takes the 4-bit ALU control code and two
// operands and returns a result with NZCV flags.
// - Logic ops, ADD, SUB and PASS B finish at the acceptance edge.
// - MUL is a WIDTH-step shift-add sequence.
// - Only one operation is in flight at a time: IDLE -> (MUL) -> DONE -> IDLE.
module alu_exec_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_exec_seq_if.slave    bus,
    output logic [1:0]       state_dbg
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_ORR  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam int         CW      = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             n_q, z_q, c_q, v_q, err_q;

    // Shift-add multiplier working registers.
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc_nxt;

    // Single-cycle datapath outputs.
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] op_res;
    logic             op_c, op_v, op_err;

    // Single-cycle datapath. SUB reuses the adder as a + ~b + 1, so C is NOT borrow.
    always_comb begin
        is_sub = (bus.code == OP_SUB);
        b_eff  = is_sub ? ~bus.b : bus.b;
        sum    = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        op_res = '0;
        op_c   = 1'b0;
        op_v   = 1'b0;
        op_err = 1'b0;
        case (bus.code)
            OP_AND:  op_res = bus.a & bus.b;
            OP_ORR:  op_res = bus.a | bus.b;
            OP_PASS: op_res = bus.b;
            OP_NOR:  op_res = ~(bus.a | bus.b);
            OP_ADD, OP_SUB: begin
                op_res = sum[WIDTH-1:0];
                op_c   = sum[WIDTH];
                op_v   = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) &&
                         (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_MUL:  op_res = '0;  // handled by the iterative path
            default: op_err = 1'b1;
        endcase
    end

    // One multiplier step: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_nxt = acc + (mplier[0] ? mcand : '0);
    end

    // Control FSM with registered result, flags and out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            err_q       <= 1'b0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            count       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.code == OP_MUL) begin
                            mcand  <= bus.a;
                            mplier <= bus.b;
                            acc    <= '0;
                            count  <= CW'(WIDTH);
                            state  <= S_MUL;
                        end else begin
                            result_q    <= op_res;
                            n_q         <= op_res[WIDTH-1];
                            z_q         <= ~|op_res;
                            c_q         <= op_c;
                            v_q         <= op_v;
                            err_q       <= op_err;
                            out_valid_q <= 1'b1;
                            state       <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        result_q    <= acc_nxt;
                        n_q         <= acc_nxt[WIDTH-1];
                        z_q         <= ~|acc_nxt;
                        c_q         <= 1'b0;
                        v_q         <= 1'b0;
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flag_n    = n_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_v    = v_q;
    assign bus.err       = err_q;
    assign state_dbg     = state;
endmodule

// File: tb/tb_alu_exec_seq.sv
// Bench for alu_exec_seq. The driver pushes an expected response for each
// accepted request. An independent monitor pops and compares each consumed
// result. The reference model uses plain wide arithmetic.
module tb_alu_exec_seq;
    localparam int W  = 64;
    localparam int EW = W + 5;  // {result, n, z, c, v, err}

    localparam logic [3:0] C_AND = 4'b0000, C_ORR = 4'b0001, C_ADD = 4'b0010,
                           C_SUB = 4'b0110, C_PASS = 4'b0111, C_NOR = 4'b1100,
                           C_MUL = 4'b1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    state_dbg;
    logic [EW-1:0] exp_q[$];
    int            tests = 0;
    int            fails = 0;
    int            ready_mode = 0;  // 0 random, 1 always ready, 2 stall

    alu_exec_seq_if #(.WIDTH(W)) bus ();

    alu_exec_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack(input logic [W-1:0] r, input logic c, input logic v,
                                           input logic e);
        return {r, r[W-1], (r == '0), c, v, e};
    endfunction

    // Reference model. It works from the arithmetic meaning of each code,
    // using wide signed/unsigned sums and a full-width product.
    function automatic logic [EW-1:0] model(input logic [3:0] c, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        logic [W-1:0]       r;
        logic               cf, vf, ef;
        logic [2*W-1:0]     p;
        logic signed [W+1:0] st;
        r = '0; cf = 1'b0; vf = 1'b0; ef = 1'b0;
        case (c)
            C_AND:  r = x & y;
            C_ORR:  r = x | y;
            C_PASS: r = y;
            C_NOR:  r = ~(x | y);
            C_ADD: begin
                {cf, r} = {1'b0, x} + {1'b0, y};
                st = $signed({{2{x[W-1]}}, x}) + $signed({{2{y[W-1]}}, y});
                vf = (st != $signed({{2{r[W-1]}}, r}));
            end
            C_SUB: begin
                r  = x - y;
                cf = (x >= y);
                st = $signed({{2{x[W-1]}}, x}) - $signed({{2{y[W-1]}}, y});
                vf = (st != $signed({{2{r[W-1]}}, r}));
            end
            C_MUL: begin
                p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                r = p[W-1:0];
            end
            default: ef = 1'b1;
        endcase
        return pack(r, cf, vf, ef);
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- driver ----------------
    // Present a request and hold it until accepted. Push its expected response at the acceptance edge.
    task automatic issue(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [EW-1:0] expv);
        int guard = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.code     = c;
        bus.a        = x;
        bus.b        = y;
        while (!bus.in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            exp_q.push_back(expv);
            #1;
            bus.in_valid = 1'b0;
            bus.code     = 4'($urandom);
            bus.a        = {$urandom, $urandom};
            bus.b        = {$urandom, $urandom};
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                case (ready_mode)
                    0:       bus.out_ready = ($urandom_range(0, 3) != 0);
                    1:       bus.out_ready = 1'b1;
                    default: bus.out_ready = 1'b0;
                endcase
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_output: got result %h, required no output",
                                 bus.result);
                    end else begin
                        chk("result_flags", {bus.result, bus.flag_n, bus.flag_z, bus.flag_c,
                                             bus.flag_v, bus.err}, exp_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int bad;
        bus.in_valid = 1'b0;
        bus.code     = '0;
        bus.a        = '0;
        bus.b        = '0;

        // Reset state.
        #1;
        chk("reset_state", {{(EW-8){1'b0}}, bus.out_valid, bus.in_ready, bus.result[5:0]},
            {{(EW-8){1'b0}}, 1'b0, 1'b1, 6'd0});
        chk("reset_flags", pack(bus.result, bus.flag_c, bus.flag_v, bus.err) ^
                           {{W{1'b0}}, 1'b0, 1'b1, 3'b0} ^ {{W{1'b0}}, bus.flag_n, bus.flag_z, 3'b0},
            '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic and logic cases.
        ready_mode = 1;
        issue(C_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, pack(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0));
        issue(C_SUB, 64'd5, 64'd5, pack(64'd0, 1'b1, 1'b0, 1'b0));
        issue(C_SUB, 64'd3, 64'd5, pack(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0));
        issue(C_AND, 64'hF0, 64'h3C, pack(64'h30, 1'b0, 1'b0, 1'b0));
        issue(C_ORR, 64'hF0, 64'h3C, pack(64'hFC, 1'b0, 1'b0, 1'b0));
        issue(C_PASS, 64'hF0, 64'h3C, pack(64'h3C, 1'b0, 1'b0, 1'b0));
        issue(C_NOR, 64'hF0, 64'h3C, pack(64'hFFFF_FFFF_FFFF_FF03, 1'b0, 1'b0, 1'b0));
        issue(C_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, pack(64'd0, 1'b1, 1'b0, 1'b0));
        drain();

        // MUL latency: busy for WIDTH edges, result appears on the WIDTH-th edge.
        issue(C_MUL, 64'd7, 64'd9, pack(64'd63, 1'b0, 1'b0, 1'b0));
        bad = 0;
        for (int i = 1; i <= W; i++) begin
            @(posedge clk);
            #1;
            if (i < W && (bus.out_valid || bus.in_ready)) bad++;
            if (i == W)
                chk("mul_latency", {{(EW-2){1'b0}}, bus.out_valid, bus.in_ready},
                    {{(EW-2){1'b0}}, 1'b1, 1'b0});
        end
        chk("mul_busy_cycles", EW'(bad), '0);
        issue(C_MUL, 64'h8000_0000_0000_0000, 64'd2, pack(64'd0, 1'b0, 1'b0, 1'b0));
        drain();

        // Backpressure with an unsupported code: the result must hold while stalled.
        ready_mode = 2;
        issue(4'b1111, {$urandom, $urandom}, {$urandom, $urandom}, pack(64'd0, 1'b0, 1'b0, 1'b1));
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.in_ready || bus.result != '0 || !bus.err || !bus.flag_z)
                bad++;
        end
        chk("stall_hold", EW'(bad), '0);
        ready_mode = 1;
        drain();

        // Reset in the middle of a MUL: the partial result must never appear.
        issue(C_MUL, {$urandom, $urandom}, {$urandom, $urandom}, '0);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("reset_mid_mul", {bus.result, bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v, bus.err},
            '0);
        chk("reset_mid_mul_hs", {{(EW-2){1'b0}}, bus.out_valid, bus.in_ready},
            {{(EW-2){1'b0}}, 1'b0, 1'b1});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issue(C_ADD, 64'd2, 64'd3, pack(64'd5, 1'b0, 1'b0, 1'b0));
        drain();

        // Randomised traffic under random backpressure, checked against the model.
        ready_mode = 0;
        for (int n = 0; n < 150; n++) begin
            logic [3:0]   c;
            logic [W-1:0] x, y;
            int           k;
            logic [3:0]   legal[6];
            logic [3:0]   illegal[9];
            legal   = '{C_AND, C_ORR, C_ADD, C_SUB, C_PASS, C_NOR};
            illegal = '{4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd13, 4'd14, 4'd15};
            k = $urandom_range(0, 19);
            if (k == 18)      c = C_MUL;
            else if (k == 19) c = illegal[$urandom_range(0, 8)];
            else              c = legal[$urandom_range(0, 5)];
            x = rand_operand();
            y = rand_operand();
            issue(c, x, y, model(c, x, y));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        ready_mode = 1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
